cmd_parser: RTL and testbench
=============================

CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter TIMEOUT, default 255: number of idle clk cycles inside a frame before the frame is aborted.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_wr  input  1  byte-valid strobe; one byte is consumed on every clk edge where cmd_wr=1.
REQ-005 cmd_in  input  8  command byte stream.
REQ-006 reg_wr  output  1  single-cycle register-write strobe.
REQ-007 reg_addr  output  8  register address, valid while reg_wr=1.
REQ-008 reg_data  output  32  register data, valid while reg_wr=1.
REQ-009 busy  output  1  high while a frame is partially received.
REQ-010 cmd_err  output  1  single-cycle error pulse.

Function
REQ-011 Frame format, opcode first: 0x01 SHORT_WR = opcode, addr, data8; 0x05 WIDE_WR = opcode, n, n data bytes little-endian, addr.
REQ-012 The FSM states shall be IDLE, S_ADDR, S_DATA, W_LEN, W_DATA, W_ADDR.
REQ-013 IDLE transitions: byte 0x01 goes to S_ADDR, byte 0x05 goes to W_LEN, and any other byte pulses cmd_err and stays in IDLE.
REQ-014 In S_ADDR the byte shall be latched as the address and the FSM shall go to S_DATA; in S_DATA the byte shall be zero-extended to 32 bits and the write issued.
REQ-015 In W_LEN, n in 1..4 shall be latched as the remaining-byte count, the data accumulator cleared, and the FSM moved to W_DATA; n=0 or n>4 shall pulse cmd_err and return to IDLE.
REQ-016 In W_DATA, byte k (0-based) shall be written to accumulator bits [8k+7:8k], with unwritten upper bytes remaining zero; after the n-th byte the FSM shall go to W_ADDR.
REQ-017 In W_ADDR the byte shall be the address and the write issued.
REQ-018 Write issue: reg_wr=1 for exactly one cycle, on the clk edge after the final frame byte is accepted (latency 1), and the FSM shall return to IDLE in that same edge.
REQ-019 reg_addr/reg_data shall hold their last written values between strobes.
REQ-020 Back-to-back frames with no gap shall be accepted: an opcode byte arriving in the cycle reg_wr is high shall be decoded normally.
REQ-021 busy=1 in every state except IDLE.
REQ-022 An idle counter shall clear on every accepted byte and increment each non-IDLE cycle with cmd_wr=0.
REQ-023 When the idle counter reaches TIMEOUT, the parser shall pulse cmd_err, return to IDLE, and issue no write.
REQ-024 If a byte arrives in the same cycle the counter would expire, the byte wins and no timeout occurs.
REQ-025 In IDLE, cmd_wr=0 shall have no effect, and the counter shall be held at 0.
REQ-026 cmd_err and reg_wr shall never assert in the same cycle.

Reset
REQ-027 Reset shall force: state IDLE; reg_wr=0; cmd_err=0; busy=0; reg_addr=0x00; reg_data=0x00000000; idle counter=0; accumulator=0.
REQ-028 Reset asserted mid-frame shall discard the frame, issue no write, and require a fresh opcode after release.

Structure
REQ-029 Opcode constants (OP_SHORT_WR=0x01, OP_WIDE_WR=0x05), the FSM state encoding and the max wide length (4) shall live in the shared timetag command package.
REQ-030 The idle-timeout counter shall be a sub-module named cmd_timeout (clear, enable, expire output).
REQ-031 The remainder shall be a single FSM plus datapath registers; no FIFO.

Verification
REQ-032 The bench shall cover stream 05 04 00 00 00 40 02 contiguous -> one reg_wr, reg_addr=0x02, reg_data=0x40000000, one cycle after the last byte.
REQ-033 The bench shall cover stream 01 02 01 immediately followed by 01 01 01 with no gap -> two reg_wr pulses, addr 0x02 then 0x01, data 0x00000001 both.
REQ-034 The bench shall cover stream 05 02 34 12 08 -> reg_addr=0x08, reg_data=0x00001234; and stream 05 00 -> cmd_err pulse, no reg_wr, busy=0 next cycle.
REQ-035 The bench shall cover byte 0x7F in IDLE followed by 01 03 AA -> one cmd_err then reg_addr=0x03, reg_data=0x000000AA.
REQ-036 The bench shall cover, with TIMEOUT=8, stream 05 04 11, then cmd_wr low 8 cycles -> cmd_err, no write, IDLE; repeat with a byte on the 8th idle cycle -> no timeout.
REQ-037 The bench shall cover reset pulsed after 05 04 00 00, then 01 04 09 -> no write from the aborted frame; write addr 0x04 data 0x00000009.

Source files
------------

// File: rtl/cmd_parser_pkg.sv
// rtl/cmd_parser_pkg.sv - opcodes, frame limits and FSM encoding for the command parser
package cmd_parser_pkg;

  localparam logic [7:0] OP_SHORT_WR  = 8'h01;
  localparam logic [7:0] OP_WIDE_WR   = 8'h05;
  localparam logic [7:0] MAX_WIDE_LEN = 8'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    W_LEN  = 3'd3,
    W_DATA = 3'd4,
    W_ADDR = 3'd5
  } state_t;

endpackage

// File: rtl/cmd_timeout.sv
// rtl/cmd_timeout.sv - idle-cycle counter that flags a stalled frame
module cmd_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  // Expire on the cycle whose increment would bring the count to TIMEOUT.
  assign expire = enable && (count == W'(TIMEOUT - 1));

  // Count stalled cycles; any clear or expiry restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - byte-stream command parser issuing register writes
module cmd_parser
  import cmd_parser_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_in,
  output logic        reg_wr,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_data,
  output logic        busy,
  output logic        cmd_err
);

  state_t      state, state_nxt;
  logic [7:0]  addr_q, addr_nxt;
  logic [31:0] acc, acc_nxt;
  logic [2:0]  rem, rem_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        wr_nxt, err_nxt;
  logic [7:0]  reg_addr_nxt;
  logic [31:0] reg_data_nxt;
  logic        expire;

  assign busy = (state != IDLE);

  cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cmd_wr || (state == IDLE)),
    .enable (busy && !cmd_wr),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath decode; a byte always beats a timeout since expire needs cmd_wr=0.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    acc_nxt      = acc;
    rem_nxt      = rem;
    idx_nxt      = idx;
    wr_nxt       = 1'b0;
    err_nxt      = 1'b0;
    reg_addr_nxt = reg_addr;
    reg_data_nxt = reg_data;
    if (expire) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else if (cmd_wr) begin
      case (state)
        IDLE: begin
          if (cmd_in == OP_SHORT_WR) begin
            state_nxt = S_ADDR;
          end else if (cmd_in == OP_WIDE_WR) begin
            state_nxt = W_LEN;
          end else begin
            err_nxt = 1'b1;
          end
        end
        S_ADDR: begin
          addr_nxt  = cmd_in;
          state_nxt = S_DATA;
        end
        S_DATA: begin
          reg_addr_nxt = addr_q;
          reg_data_nxt = {24'h000000, cmd_in};
          wr_nxt       = 1'b1;
          state_nxt    = IDLE;
        end
        W_LEN: begin
          if ((cmd_in != 8'd0) && (cmd_in <= MAX_WIDE_LEN)) begin
            rem_nxt   = cmd_in[2:0];
            idx_nxt   = 2'd0;
            acc_nxt   = 32'h0;
            state_nxt = W_DATA;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
        W_DATA: begin
          acc_nxt[{idx, 3'b000} +: 8] = cmd_in;
          idx_nxt = idx + 2'd1;
          rem_nxt = rem - 3'd1;
          if (rem == 3'd1) begin
            state_nxt = W_ADDR;
          end
        end
        W_ADDR: begin
          reg_addr_nxt = cmd_in;
          reg_data_nxt = acc;
          wr_nxt       = 1'b1;
          state_nxt    = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Datapath and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= 8'h00;
      acc      <= 32'h0;
      rem      <= 3'd0;
      idx      <= 2'd0;
      reg_wr   <= 1'b0;
      cmd_err  <= 1'b0;
      reg_addr <= 8'h00;
      reg_data <= 32'h0;
    end else begin
      addr_q   <= addr_nxt;
      acc      <= acc_nxt;
      rem      <= rem_nxt;
      idx      <= idx_nxt;
      reg_wr   <= wr_nxt;
      cmd_err  <= err_nxt;
      reg_addr <= reg_addr_nxt;
      reg_data <= reg_data_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// tb/tb_cmd_parser.sv - randomized and directed bench for cmd_parser against a frame-level model
module tb_cmd_parser;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_wr = 1'b0;
  logic [7:0]  cmd_in = 8'h00;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [31:0] reg_data;
  logic        busy;
  logic        cmd_err;

  cmd_parser #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_wr   (cmd_wr),
    .cmd_in   (cmd_in),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Model state: bytes of the frame received so far, stall cycles since last byte.
  logic [7:0]  frame_q[$];
  int          idle_cnt = 0;
  logic        exp_wr = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_busy = 1'b0;
  logic [7:0]  exp_addr = 8'h00;
  logic [31:0] exp_data = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vectors++;
    if (got !== want) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    idle_cnt = 0;
    exp_wr   = 1'b0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
    exp_addr = 8'h00;
    exp_data = 32'h0;
  endtask

  // Interpret the frame as a whole once each byte lands.
  task automatic model_step(input logic wr, input logic [7:0] b);
    int n;
    exp_wr  = 1'b0;
    exp_err = 1'b0;
    if (wr) begin
      idle_cnt = 0;
      frame_q.push_back(b);
      if (frame_q[0] != 8'h01 && frame_q[0] != 8'h05) begin
        exp_err = 1'b1;
        frame_q.delete();
      end else if (frame_q[0] == 8'h01 && frame_q.size() == 3) begin
        exp_wr   = 1'b1;
        exp_addr = frame_q[1];
        exp_data = 32'(frame_q[2]);
        frame_q.delete();
      end else if (frame_q[0] == 8'h05 && frame_q.size() >= 2) begin
        n = int'(frame_q[1]);
        if (n == 0 || n > 4) begin
          exp_err = 1'b1;
          frame_q.delete();
        end else if (frame_q.size() == n + 3) begin
          exp_data = 32'h0;
          for (int k = 0; k < n; k++) exp_data = exp_data | (32'(frame_q[2 + k]) << (8 * k));
          exp_addr = frame_q[n + 2];
          exp_wr   = 1'b1;
          frame_q.delete();
        end
      end
    end else if (frame_q.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin
        exp_err = 1'b1;
        frame_q.delete();
        idle_cnt = 0;
      end
    end
    exp_busy = (frame_q.size() > 0);
  endtask

  task automatic step(input logic wr, input logic [7:0] b);
    cmd_wr = wr;
    cmd_in = b;
    model_step(wr, b);
    @(posedge clk);
    #1;
    cmd_wr = 1'b0;
    check("reg_wr", 32'(reg_wr), 32'(exp_wr));
    check("cmd_err", 32'(cmd_err), 32'(exp_err));
    check("busy", 32'(busy), 32'(exp_busy));
    check("reg_addr", 32'(reg_addr), 32'(exp_addr));
    check("reg_data", reg_data, exp_data);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    cmd_wr = 1'b0;
    reset  = 1'b1;
    #1;
    model_reset();
    check("rst_reg_wr", 32'(reg_wr), 32'h0);
    check("rst_cmd_err", 32'(cmd_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_reg_addr", 32'(reg_addr), 32'h0);
    check("rst_reg_data", reg_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [7:0] a, input logic [31:0] d);
    check({tag, "_wr"}, 32'(reg_wr), 32'h1);
    check({tag, "_addr"}, 32'(reg_addr), 32'(a));
    check({tag, "_data"}, reg_data, d);
  endtask

  initial begin
    int kind, n, g;
    logic [7:0] bytes[$];

    #3;
    do_reset();

    // Wide write, four bytes, top byte only set.
    send(8'h05); send(8'h04); send(8'h00); send(8'h00); send(8'h00); send(8'h40);
    check("w4_no_early_wr", 32'(reg_wr), 32'h0);
    send(8'h02);
    expect_write("w4", 8'h02, 32'h40000000);
    gap(1);
    check("w4_single_pulse", 32'(reg_wr), 32'h0);

    // Two short writes back to back.
    send(8'h01); send(8'h02); send(8'h01);
    expect_write("sw1", 8'h02, 32'h00000001);
    send(8'h01); send(8'h01); send(8'h01);
    expect_write("sw2", 8'h01, 32'h00000001);
    gap(1);

    // Two-byte wide write, then zero length.
    send(8'h05); send(8'h02); send(8'h34); send(8'h12); send(8'h08);
    expect_write("w2", 8'h08, 32'h00001234);
    send(8'h05); send(8'h00);
    check("len0_err", 32'(cmd_err), 32'h1);
    check("len0_no_wr", 32'(reg_wr), 32'h0);
    check("len0_busy", 32'(busy), 32'h0);
    gap(1);

    // Bad opcode then a good short write.
    send(8'h7F);
    check("badop_err", 32'(cmd_err), 32'h1);
    send(8'h01); send(8'h03); send(8'hAA);
    expect_write("after_bad", 8'h03, 32'h000000AA);
    gap(1);

    // Timeout after exactly TMO idle cycles.
    send(8'h05); send(8'h04); send(8'h11);
    gap(TMO - 1);
    check("tmo_not_yet", 32'(cmd_err), 32'h0);
    check("tmo_still_busy", 32'(busy), 32'h1);
    gap(1);
    check("tmo_err", 32'(cmd_err), 32'h1);
    check("tmo_idle", 32'(busy), 32'h0);
    check("tmo_no_wr", 32'(reg_wr), 32'h0);
    gap(2);

    // Byte on the last idle cycle rescues the frame.
    send(8'h05); send(8'h04); send(8'h11);
    gap(TMO - 1);
    send(8'h22);
    check("rescue_no_err", 32'(cmd_err), 32'h0);
    check("rescue_busy", 32'(busy), 32'h1);
    send(8'h33); send(8'h44); send(8'h55);
    expect_write("rescue", 8'h55, 32'h44332211);
    gap(1);

    // Reset mid-frame discards it.
    send(8'h05); send(8'h04); send(8'h00); send(8'h00);
    do_reset();
    send(8'h01); send(8'h04); send(8'h09);
    expect_write("post_rst", 8'h04, 32'h00000009);
    gap(1);

    // Randomized frames with irregular gaps, stalls and occasional resets.
    for (int f = 0; f < 300; f++) begin
      bytes.delete();
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        bytes.push_back(8'h01);
        bytes.push_back(8'($urandom));
        bytes.push_back(8'($urandom));
      end else if (kind < 8) begin
        n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(1, 4);
        bytes.push_back(8'h05);
        bytes.push_back(8'(n));
        for (int k = 0; k < n; k++) bytes.push_back(8'($urandom));
        bytes.push_back(8'($urandom));
      end else begin
        bytes.push_back(8'($urandom));
      end
      foreach (bytes[i]) begin
        g = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 2, TMO + 1) : $urandom_range(0, 1);
        gap(g);
        send(bytes[i]);
      end
      if ($urandom_range(0, 49) == 0) do_reset();
    end
    gap(TMO + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
